// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment driver: hex decode, anode scanning, and double-buffered digit load.
// Define SEG_SCAN_DP_EN to add the per-digit decimal point (dp_in / dp).
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
`ifdef SEG_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pend_flag;

  logic                    div_tc;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    all_zero;
  logic [3:0]              cur_nib;
  logic                    cur_blank;

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0]   dp_pending;
  logic [NUM_DIGITS-1:0]   dp_shadow;
  logic                    cur_dp;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    seg_decode = 7'h7F;
    case (nib)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      4'hF: seg_decode = 7'b0001110;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign div_tc   = (div_cnt == DIV_LAST);
  assign boundary = enable && div_tc && (idx == IDX_LAST);

  // Blank mask walks from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      all_zero = all_zero & (shadow[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if ((LZ_BLANK != 0) && (i != NUM_DIGITS - 1))
        lz_mask[NUM_DIGITS-1-i] = all_zero;
    end
    cur_nib   = '0;
    cur_blank = 1'b0;
`ifdef SEG_SCAN_DP_EN
    cur_dp    = 1'b0;
`endif
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = shadow[4*k +: 4];
        cur_blank = lz_mask[k];
`ifdef SEG_SCAN_DP_EN
        cur_dp    = dp_shadow[k];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      if (!enable) begin
        div_cnt <= '0;
        idx     <= '0;
      end else if (div_tc) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      frame_done <= boundary;
    end
  end

  // A load on the boundary cycle bypasses pending so the new frame shows it immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      dp_shadow  <= '0;
      dp_pending <= '0;
`endif
    end else if (boundary && load) begin
      shadow    <= digits_in;
      pend_flag <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      dp_shadow <= dp_in;
`endif
    end else if (boundary && pend_flag) begin
      shadow    <= pending;
      pend_flag <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      dp_shadow <= dp_pending;
`endif
    end else if (load) begin
      pending   <= digits_in;
      pend_flag <= 1'b1;
`ifdef SEG_SCAN_DP_EN
      dp_pending <= dp_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      anode   <= '1;
      cathode <= 7'h7F;
`ifdef SEG_SCAN_DP_EN
      dp      <= 1'b1;
`endif
    end else begin
      anode   <= ~(NUM_DIGITS'(1) << idx);
      cathode <= cur_blank ? 7'h7F : seg_decode(cur_nib);
`ifdef SEG_SCAN_DP_EN
      dp      <= ~(cur_dp & ~cur_blank);
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4-cycle refresh; a second instance has leading-zero blanking.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  anode, lz_anode;
  logic [6:0]  cathode, lz_cathode;
  logic        frame_done, lz_frame_done;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  dp_in = '0;
  logic        dp, lz_dp;
`endif

  int          total = 0;
  int          bad   = 0;
  int          pos;
  logic [15:0] exp_shadow;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .load(load),
`ifdef SEG_SCAN_DP_EN
    .dp_in(dp_in), .dp(dp),
`endif
    .anode(anode), .cathode(cathode), .frame_done(frame_done)
  );

  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .load(load),
`ifdef SEG_SCAN_DP_EN
    .dp_in(dp_in), .dp(lz_dp),
`endif
    .anode(lz_anode), .cathode(lz_cathode), .frame_done(lz_frame_done)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // After enabled edge p (p = 1 is the first), the outputs show digit ((p-1)/4) mod 4.
  function automatic int digit_at(input int p);
    return ((p - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << digit_at(p));
  endfunction

  function automatic logic [6:0] exp_cat(input logic [15:0] s, input int p);
    return seg(s[digit_at(p)*4 +: 4]);
  endfunction

  function automatic logic exp_fd(input int p);
    return (p % 16) == 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; load = 1'b0; digits_in = '0;
    tick; tick;
    total++;
    if ({anode, cathode, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL reset: anode=%b cathode=%b fd=%b expected 1111 1111111 0", anode, cathode, frame_done);
    end
    total++;
    if ({lz_anode, lz_cathode, lz_frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL reset_lz: anode=%b cathode=%b fd=%b expected 1111 1111111 0", lz_anode, lz_cathode, lz_frame_done);
    end
    rst = 1'b0;
    pos = 0;
    exp_shadow = '0;
  endtask

  task automatic test_scan;
    repeat (32) begin
      tick; pos++;
      total++;
      if ({anode, cathode, frame_done} !== {exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos)}) begin
        bad++;
        $display("FAIL scan pos=%0d: anode=%b cathode=%b fd=%b expected %b %b %b", pos, anode, cathode,
                 frame_done, exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos));
      end
    end
  endtask

  task automatic test_midframe_load;
    repeat (32) begin
      load = (pos == 37);
      digits_in = 16'h12AF;
      tick; pos++;
      load = 1'b0;
      if (pos == 49) exp_shadow = 16'h12AF;
      total++;
      if ({anode, cathode, frame_done} !== {exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos)}) begin
        bad++;
        $display("FAIL midframe_load pos=%0d: anode=%b cathode=%b fd=%b expected %b %b %b", pos, anode,
                 cathode, frame_done, exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos));
      end
    end
  endtask

  task automatic test_multi_load;
    repeat (64) begin
      load = 1'b0;
      if (pos == 65) begin load = 1'b1; digits_in = 16'h1111; end
      if (pos == 69) begin load = 1'b1; digits_in = 16'h2222; end
      if (pos == 95) begin load = 1'b1; digits_in = 16'h3333; end
      tick; pos++;
      load = 1'b0;
      if (pos == 81) exp_shadow = 16'h2222;
      if (pos == 97) exp_shadow = 16'h3333;
      total++;
      if ({anode, cathode, frame_done} !== {exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos)}) begin
        bad++;
        $display("FAIL multi_load pos=%0d: anode=%b cathode=%b fd=%b expected %b %b %b", pos, anode,
                 cathode, frame_done, exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos));
      end
    end
  endtask

  task automatic test_lz_blank;
    logic [6:0] lz_0050 [4];
    logic [6:0] lz_0000 [4];
    logic [6:0] lz_exp;
    lz_0050 = '{7'b1000000, 7'b0010010, 7'h7F, 7'h7F};
    lz_0000 = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
    repeat (48) begin
      load = 1'b0;
      if (pos == 129) begin load = 1'b1; digits_in = 16'h0050; end
      if (pos == 149) begin load = 1'b1; digits_in = 16'h0000; end
      tick; pos++;
      load = 1'b0;
      if (pos == 145) exp_shadow = 16'h0050;
      if (pos == 161) exp_shadow = 16'h0000;
      total++;
      if ({anode, cathode, frame_done} !== {exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos)}) begin
        bad++;
        $display("FAIL lz_plain pos=%0d: anode=%b cathode=%b fd=%b expected %b %b %b", pos, anode,
                 cathode, frame_done, exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos));
      end
      if (pos >= 145) begin
        lz_exp = (pos >= 161) ? lz_0000[digit_at(pos)] : lz_0050[digit_at(pos)];
        total++;
        if ({lz_anode, lz_cathode, lz_frame_done} !== {exp_an(pos), lz_exp, exp_fd(pos)}) begin
          bad++;
          $display("FAIL lz_blank pos=%0d: anode=%b cathode=%b fd=%b expected %b %b %b", pos, lz_anode,
                   lz_cathode, lz_frame_done, exp_an(pos), lz_exp, exp_fd(pos));
        end
      end
    end
  endtask

  task automatic test_disable;
    repeat (6) begin tick; pos++; end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load = (i == 2);
      digits_in = 16'h0707;
      tick;
      load = 1'b0;
      total++;
      if ({anode, cathode, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
        bad++;
        $display("FAIL disable i=%0d: anode=%b cathode=%b fd=%b expected 1111 1111111 0", i, anode,
                 cathode, frame_done);
      end
    end
    enable = 1'b1;
    pos = 0;
    repeat (32) begin
      tick; pos++;
      if (pos == 17) exp_shadow = 16'h0707;
      total++;
      if ({anode, cathode, frame_done} !== {exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos)}) begin
        bad++;
        $display("FAIL reenable pos=%0d: anode=%b cathode=%b fd=%b expected %b %b %b", pos, anode,
                 cathode, frame_done, exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos));
      end
    end
  endtask

  task automatic test_reset_midframe;
    repeat (9) begin
      load = (pos == 37);
      digits_in = 16'h9999;
      tick; pos++;
      load = 1'b0;
      total++;
      if ({anode, cathode} !== {exp_an(pos), exp_cat(exp_shadow, pos)}) begin
        bad++;
        $display("FAIL pre_reset pos=%0d: anode=%b cathode=%b expected %b %b", pos, anode, cathode,
                 exp_an(pos), exp_cat(exp_shadow, pos));
      end
    end
    rst = 1'b1; load = 1'b1; digits_in = 16'h8888;
    tick;
    rst = 1'b0; load = 1'b0;
    total++;
    if ({anode, cathode, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL reset_midframe: anode=%b cathode=%b fd=%b expected 1111 1111111 0", anode, cathode,
               frame_done);
    end
    pos = 0;
    exp_shadow = '0;
    repeat (32) begin
      tick; pos++;
      total++;
      if ({anode, cathode, frame_done} !== {exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos)}) begin
        bad++;
        $display("FAIL post_reset pos=%0d: anode=%b cathode=%b fd=%b expected %b %b %b", pos, anode,
                 cathode, frame_done, exp_an(pos), exp_cat(exp_shadow, pos), exp_fd(pos));
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_midframe_load;
    test_multi_load;
    test_lz_blank;
    test_disable;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
